pin_entry_checker: RTL and testbench

//  Consumes the one-cycle, one-hot digit pulses from the keypad edge stage and builds a PIN_LEN-digit BCD entry.
//  On enter, it compares the entry with the stored PIN and then opens the door, flags an error, or enters lockout.

---
 rtl/pin_entry_checker.sv | 204 ++++++++++++++++++++
 tb/tb_pin_entry_checker.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_entry_checker.sv
// PIN entry checker: collects one-hot keypad digit pulses into a BCD entry,
// compares it with the stored PIN on enter, and drives the door, error and
// lockout indications. A new PIN can be stored while the door is open.
module pin_entry_checker #(
  parameter int unsigned               PIN_LEN     = 4,
  parameter logic [PIN_LEN*4-1:0]      DEFAULT_PIN = 16'h1234,
  parameter int unsigned               MAX_FAIL    = 3,
  parameter int unsigned               OPEN_CYCLES = 50_000_000,
  parameter int unsigned               LOCK_CYCLES = 250_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] digit_in,
  input  logic       enter,
  input  logic       clear,
  input  logic       set_pin,
  output logic       door_open,
  output logic       err_pulse,
  output logic       locked,
  output logic       pin_changed,
  output logic [3:0] entry_count
);

  localparam int unsigned BW   = PIN_LEN * 4;
  localparam int unsigned TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [3:0]    CNT_FULL  = 4'(PIN_LEN);
  localparam logic [3:0]    FAIL_MAX  = 4'(MAX_FAIL);
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_FAIL,
    S_LOCKOUT
  } state_t;

  state_t          state_q, state_n;
  logic [BW-1:0]   buf_q,   buf_n;
  logic [BW-1:0]   pin_q,   pin_n;
  logic [3:0]      cnt_q,   cnt_n;
  logic [3:0]      fail_q,  fail_n;
  logic [TW-1:0]   timer_q, timer_n;
  logic            chg_n;

  logic            door_q, err_q, lock_q, chg_q;

  logic            digit_valid;
  logic            digit_take;
  logic [3:0]      digit_bcd;
  logic            entry_full;
  logic [3:0]      fail_inc;

  // Exactly one key bit set counts as a digit; anything else is noise.
  function automatic logic is_onehot(input logic [9:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (v[i]) n++;
    end
    return (n == 1);
  endfunction

  function automatic logic [3:0] to_bcd(input logic [9:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (v[i]) c = 4'(i);
    end
    return c;
  endfunction

  // Decode the keypad pulse and decide whether it may enter the buffer.
  always_comb begin
    digit_valid = is_onehot(digit_in);
    digit_bcd   = to_bcd(digit_in);
    entry_full  = (cnt_q == CNT_FULL);
    digit_take  = digit_valid && !entry_full;
    fail_inc    = fail_q + 4'd1;
  end

  // Next-state, entry buffer, stored PIN and failure counter.
  always_comb begin
    state_n = state_q;
    buf_n   = buf_q;
    cnt_n   = cnt_q;
    pin_n   = pin_q;
    fail_n  = fail_q;
    chg_n   = 1'b0;

    unique case (state_q)
      S_ENTRY: begin
        if (clear) begin
          buf_n = '0;
          cnt_n = '0;
        end else if (enter) begin
          state_n = S_CHECK;
        end else if (digit_take) begin
          // shift the new digit in at the least significant nibble
          buf_n = BW'({buf_q, digit_bcd});
          cnt_n = cnt_q + 4'd1;
        end
      end

      S_CHECK: begin
        if (entry_full && (buf_q == pin_q)) begin
          state_n = S_OPEN;
          fail_n  = '0;
        end else begin
          state_n = S_FAIL;
        end
        buf_n = '0;
        cnt_n = '0;
      end

      S_OPEN: begin
        if (clear) begin
          buf_n = '0;
          cnt_n = '0;
        end else if (set_pin) begin
          if (entry_full) begin
            pin_n = buf_q;
            chg_n = 1'b1;
            buf_n = '0;
            cnt_n = '0;
          end
        end else if (digit_take) begin
          buf_n = BW'({buf_q, digit_bcd});
          cnt_n = cnt_q + 4'd1;
        end
        // timeout overrides any buffer update made above on the last cycle
        if (timer_q == OPEN_LAST) begin
          state_n = S_ENTRY;
          buf_n   = '0;
          cnt_n   = '0;
        end
      end

      S_FAIL: begin
        fail_n = fail_inc;
        if (fail_inc == FAIL_MAX) state_n = S_LOCKOUT;
        else                      state_n = S_ENTRY;
      end

      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_n = S_ENTRY;
          fail_n  = '0;
        end
      end

      default: begin
        state_n = S_ENTRY;
        buf_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // Dwell timer: restarts at zero whenever the state changes.
  always_comb begin
    if ((state_n == state_q) && ((state_q == S_OPEN) || (state_q == S_LOCKOUT)))
      timer_n = timer_q + TW'(1);
    else
      timer_n = '0;
  end

  // State and datapath registers, plus registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ENTRY;
      buf_q   <= '0;
      cnt_q   <= '0;
      pin_q   <= DEFAULT_PIN;
      fail_q  <= '0;
      timer_q <= '0;
      door_q  <= 1'b0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      buf_q   <= buf_n;
      cnt_q   <= cnt_n;
      pin_q   <= pin_n;
      fail_q  <= fail_n;
      timer_q <= timer_n;
      door_q  <= (state_n == S_OPEN);
      err_q   <= (state_n == S_FAIL);
      lock_q  <= (state_n == S_LOCKOUT);
      chg_q   <= chg_n;
    end
  end

  assign door_open   = door_q;
  assign err_pulse   = err_q;
  assign locked      = lock_q;
  assign pin_changed = chg_q;
  assign entry_count = cnt_q;

endmodule

// File: tb/tb_pin_entry_checker.sv
// Bench for pin_entry_checker: directed scenarios plus random keypad traffic,
// checked every cycle against a digit-queue model of the lock.
module tb_pin_entry_checker;

  localparam int PIN_LEN = 4;
  localparam int MAX_F   = 3;
  localparam int OPEN_N  = 8;
  localparam int LOCK_N  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] digit_in;
  logic       enter, clear, set_pin;
  logic       door_open, err_pulse, locked, pin_changed;
  logic [3:0] entry_count;

  int n_pass  = 0;
  int n_total = 0;

  pin_entry_checker #(
    .PIN_LEN    (PIN_LEN),
    .DEFAULT_PIN(16'h1234),
    .MAX_FAIL   (MAX_F),
    .OPEN_CYCLES(OPEN_N),
    .LOCK_CYCLES(LOCK_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_in   (digit_in),
    .enter      (enter),
    .clear      (clear),
    .set_pin    (set_pin),
    .door_open  (door_open),
    .err_pulse  (err_pulse),
    .locked     (locked),
    .pin_changed(pin_changed),
    .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  // Model: typed digits in a queue, PIN as a digit array, and the door /
  // lockout as "cycles remaining" counters.
  int m_q[$];
  int m_pin[PIN_LEN];
  int m_open, m_lock, m_fails;
  bit m_chk, m_failp, m_chg;
  bit started = 0;

  function automatic int ones(input logic [9:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic int digit_of(input logic [9:0] v);
    int d;
    d = 0;
    for (int i = 0; i < 10; i++) if (v[i]) d = i;
    return d;
  endfunction

  function automatic bit entry_matches();
    if (m_q.size() != PIN_LEN) return 0;
    for (int i = 0; i < PIN_LEN; i++) if (m_q[i] != m_pin[i]) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    started = 1;
    m_chg   = 0;
    if (rst) begin
      m_q.delete();
      m_pin   = '{1, 2, 3, 4};
      m_open  = 0;
      m_lock  = 0;
      m_fails = 0;
      m_chk   = 0;
      m_failp = 0;
    end else if (m_chk) begin
      m_chk = 0;
      if (entry_matches()) begin
        m_open  = OPEN_N;
        m_fails = 0;
      end else begin
        m_failp = 1;
      end
      m_q.delete();
    end else if (m_failp) begin
      m_failp = 0;
      m_fails++;
      if (m_fails == MAX_F) m_lock = LOCK_N;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_open > 0) begin
      if (clear) m_q.delete();
      else if (set_pin) begin
        if (m_q.size() == PIN_LEN) begin
          for (int i = 0; i < PIN_LEN; i++) m_pin[i] = m_q[i];
          m_chg = 1;
          m_q.delete();
        end
      end else if (ones(digit_in) == 1 && m_q.size() < PIN_LEN)
        m_q.push_back(digit_of(digit_in));
      m_open--;
      if (m_open == 0) m_q.delete();
    end else begin
      if (clear) m_q.delete();
      else if (enter) m_chk = 1;
      else if (ones(digit_in) == 1 && m_q.size() < PIN_LEN)
        m_q.push_back(digit_of(digit_in));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("door_open",   32'(door_open),   32'(m_open > 0));
      chk("err_pulse",   32'(err_pulse),   32'(m_failp));
      chk("locked",      32'(locked),      32'(m_lock > 0));
      chk("pin_changed", 32'(pin_changed), 32'(m_chg));
      chk("entry_count", 32'(entry_count), 32'(m_q.size()));
    end
  end

  task automatic pulse(input logic [9:0] d, input logic e, input logic c, input logic s);
    digit_in = d; enter = e; clear = c; set_pin = s;
    @(posedge clk); #1;
    digit_in = '0; enter = 0; clear = 0; set_pin = 0;
  endtask

  function automatic logic [9:0] hot(input int k);
    logic [9:0] v;
    v = 10'd1 << k;
    return v;
  endfunction

  task automatic key(input int k);
    pulse(hot(k), 0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1; @(posedge clk); #1; rst = 0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((m_open > 0 || m_lock > 0 || m_chk || m_failp) && k < 200) begin
      idle(1);
      k++;
    end
    if (k >= 200) begin
      n_total++;
      $display("FAIL wait_idle: model still busy after %0d cycles", k);
    end
  endtask

  task automatic type4(input int a, input int b, input int c, input int d);
    key(a); key(b); key(c); key(d);
  endtask

  initial begin
    int cnt;
    rst = 1; digit_in = '0; enter = 0; clear = 0; set_pin = 0;
    idle(2);
    chk("reset_door", 32'(door_open), 0);
    chk("reset_count", 32'(entry_count), 0);
    rst = 0;

    // correct PIN opens the door for exactly OPEN_N cycles
    key(1); chk("count1", 32'(entry_count), 1);
    key(2); chk("count2", 32'(entry_count), 2);
    key(3); chk("count3", 32'(entry_count), 3);
    key(4); chk("count4", 32'(entry_count), 4);
    pulse('0, 1, 0, 0);
    chk("door_in_check", 32'(door_open), 0);
    idle(1);
    cnt = 0;
    while (door_open === 1'b1 && cnt < 50) begin cnt++; idle(1); end
    chk("door_cycles", 32'(cnt), 8);
    wait_idle();

    // wrong PIN
    type4(1, 2, 3, 5); pulse('0, 1, 0, 0); idle(1);
    chk("err_wrong", 32'(err_pulse), 1);
    idle(1);
    chk("err_one_cycle", 32'(err_pulse), 0);
    chk("count_after_err", 32'(entry_count), 0);
    wait_idle();

    // reset failure count, then three wrong PINs into lockout
    type4(1, 2, 3, 4); pulse('0, 1, 0, 0); wait_idle();
    for (int r = 0; r < 3; r++) begin
      type4(5, 5, 5, 5); pulse('0, 1, 0, 0);
      if (r < 2) wait_idle();
    end
    idle(1); chk("err_third", 32'(err_pulse), 1);
    idle(1); chk("locked_rise", 32'(locked), 1);
    type4(1, 2, 3, 4);
    chk("count_in_lock", 32'(entry_count), 0);
    pulse('0, 1, 0, 0);
    cnt = 5;
    while (locked === 1'b1 && cnt < 60) begin cnt++; idle(1); end
    chk("lock_cycles", 32'(cnt), 16);
    wait_idle();
    type4(1, 2, 3, 4); pulse('0, 1, 0, 0); idle(1);
    chk("open_after_lock", 32'(door_open), 1);
    wait_idle();

    // short entry, overflow digit, multi-bit noise
    key(1); key(2); pulse('0, 1, 0, 0); idle(1);
    chk("err_short", 32'(err_pulse), 1);
    wait_idle();
    type4(1, 2, 3, 4); key(9);
    chk("count_saturate", 32'(entry_count), 4);
    pulse('0, 1, 0, 0); idle(1);
    chk("open_5th_dropped", 32'(door_open), 1);
    wait_idle();
    key(3); pulse(10'b0000000110, 0, 0, 0);
    chk("multibit_ignored", 32'(entry_count), 1);
    pulse('0, 0, 1, 0);

    // store a new PIN while open
    type4(1, 2, 3, 4); pulse('0, 1, 0, 0); idle(1);
    type4(9, 8, 7, 6); pulse('0, 0, 0, 1);
    chk("pin_changed", 32'(pin_changed), 1);
    chk("door_stays", 32'(door_open), 1);
    idle(1);
    chk("pin_changed_pulse", 32'(pin_changed), 0);
    wait_idle();
    type4(1, 2, 3, 4); pulse('0, 1, 0, 0); idle(1);
    chk("old_pin_fails", 32'(err_pulse), 1);
    wait_idle();
    type4(9, 8, 7, 6); pulse('0, 1, 0, 0); idle(1);
    chk("new_pin_opens", 32'(door_open), 1);
    wait_idle();
    do_reset();
    type4(1, 2, 3, 4); pulse('0, 1, 0, 0); idle(1);
    chk("reset_restores_pin", 32'(door_open), 1);
    wait_idle();

    // same-cycle priorities and reset during OPEN
    key(1); key(2); pulse(hot(5), 0, 1, 0);
    chk("clear_beats_digit", 32'(entry_count), 0);
    key(1); key(2); key(3); pulse(hot(4), 1, 0, 0); idle(1);
    chk("enter_beats_digit", 32'(err_pulse), 1);
    wait_idle();
    type4(1, 2, 3, 4); pulse('0, 1, 0, 0); idle(2);
    rst = 1; @(posedge clk); #1;
    chk("rst_aborts_open", 32'(door_open), 0);
    rst = 0;

    // random traffic
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 12))
        0, 1: begin
          for (int i = 0; i < PIN_LEN; i++) key(m_pin[i]);
          pulse('0, 1, 0, 0);
        end
        2, 3: repeat ($urandom_range(1, 5)) key($urandom_range(0, 9));
        4: pulse('0, 1, 0, 0);
        5: pulse('0, 0, 1, 0);
        6: if (m_open > 1) pulse('0, 0, 0, 1); else idle(1);
        7: idle($urandom_range(1, 6));
        8: pulse(10'($urandom), 0, 0, 0);
        9: pulse(hot($urandom_range(0, 9)), 0, 1, 0);
        10: if (m_open == 0 && m_lock == 0 && !m_chk && !m_failp)
              pulse(hot($urandom_range(0, 9)), 1, 0, 0);
            else idle(1);
        11: if ($urandom_range(0, 9) == 0) do_reset(); else wait_idle();
        default: begin
          if (m_open > 6) begin
            for (int i = 0; i < PIN_LEN; i++) key($urandom_range(0, 9));
            if (m_open > 1) pulse('0, 0, 0, 1);
          end else idle(1);
        end
      endcase
    end
    wait_idle();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
